// File: rtl/xy_router_node.sv
// Mesh router node: per-input FIFOs, XY dimension-order routing on a header
// carried in the top bits of each flit, and one round-robin arbiter per output.
module xy_router_node #(
  parameter int NUM_PORTS   = 5,
  parameter int DATA_WIDTH  = 16,
  parameter int COORD_WIDTH = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int NODE_X      = 0,
  parameter int NODE_Y      = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            in_valid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  output logic [NUM_PORTS-1:0]            in_full,
  output logic [NUM_PORTS-1:0]            out_valid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] out_data,
  input  logic [NUM_PORTS-1:0]            out_full,
  output logic [7:0]                      drop_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [COORD_WIDTH-1:0] HERE_X     = COORD_WIDTH'(NODE_X);
  localparam logic [COORD_WIDTH-1:0] HERE_Y     = COORD_WIDTH'(NODE_Y);
  localparam logic [2:0]             PORT_LIMIT = 3'(NUM_PORTS);
  localparam logic [CW-1:0]          FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0]          LAST_PORT  = PW'(NUM_PORTS - 1);

  localparam logic [2:0] DIR_LOCAL = 3'd0;
  localparam logic [2:0] DIR_EAST  = 3'd1;
  localparam logic [2:0] DIR_WEST  = 3'd2;
  localparam logic [2:0] DIR_NORTH = 3'd3;
  localparam logic [2:0] DIR_SOUTH = 3'd4;

  logic [DATA_WIDTH-1:0]  fifo_mem [NUM_PORTS][FIFO_DEPTH];
  logic [AW-1:0]          rd_ptr   [NUM_PORTS];
  logic [AW-1:0]          wr_ptr   [NUM_PORTS];
  logic [CW-1:0]          count    [NUM_PORTS];
  logic [PW-1:0]          arb_ptr  [NUM_PORTS];

  logic [DATA_WIDTH-1:0]  head     [NUM_PORTS];
  logic [COORD_WIDTH-1:0] dest_x   [NUM_PORTS];
  logic [COORD_WIDTH-1:0] dest_y   [NUM_PORTS];
  logic [2:0]             route    [NUM_PORTS];
  logic [PW-1:0]          grant_idx[NUM_PORTS];

  logic [NUM_PORTS-1:0]   not_empty;
  logic [NUM_PORTS-1:0]   full_q;
  logic [NUM_PORTS-1:0]   push;
  logic [NUM_PORTS-1:0]   pop;
  logic [NUM_PORTS-1:0]   drop;
  logic [NUM_PORTS-1:0]   grant_vld;
  logic [NUM_PORTS*DATA_WIDTH-1:0] grant_data;

  logic [3:0]             drop_sum;
  logic [8:0]             drop_total;
  logic [7:0]             drop_next;

  // Route decision on every FIFO head; out-of-range targets become drops
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      head[i]      = fifo_mem[i][rd_ptr[i]];
      dest_x[i]    = head[i][DATA_WIDTH-1 -: COORD_WIDTH];
      dest_y[i]    = head[i][DATA_WIDTH-COORD_WIDTH-1 -: COORD_WIDTH];
      not_empty[i] = (count[i] != '0);
      full_q[i]    = (count[i] == FULL_COUNT);
      if (dest_x[i] > HERE_X)      route[i] = DIR_EAST;
      else if (dest_x[i] < HERE_X) route[i] = DIR_WEST;
      else if (dest_y[i] > HERE_Y) route[i] = DIR_NORTH;
      else if (dest_y[i] < HERE_Y) route[i] = DIR_SOUTH;
      else                         route[i] = DIR_LOCAL;
      drop[i] = not_empty[i] && (route[i] >= PORT_LIMIT);
    end
  end

  // Full is judged on registered occupancy, so a same-cycle pop never frees room
  assign push = in_valid & ~full_q;

  // Per-output round-robin scan starting at that output's pointer
  always_comb begin
    int            cand;
    logic [PW-1:0] cand_idx;
    cand       = 0;
    cand_idx   = '0;
    grant_vld  = '0;
    grant_data = '0;
    pop        = drop;
    for (int o = 0; o < NUM_PORTS; o++) begin
      grant_idx[o] = '0;
      for (int off = 0; off < NUM_PORTS; off++) begin
        cand = int'(arb_ptr[o]) + off;
        if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
        cand_idx = PW'(cand);
        if (!grant_vld[o] && !out_full[o] && not_empty[cand_idx] &&
            (route[cand_idx] == 3'(o))) begin
          grant_vld[o] = 1'b1;
          grant_idx[o] = cand_idx;
        end
      end
      if (grant_vld[o]) begin
        pop[grant_idx[o]]                      = 1'b1;
        grant_data[o*DATA_WIDTH +: DATA_WIDTH] = head[grant_idx[o]];
      end
    end
  end

  always_comb begin
    drop_sum = '0;
    for (int i = 0; i < NUM_PORTS; i++) drop_sum = drop_sum + 4'(drop[i]);
    drop_total = {1'b0, drop_count} + {5'b0, drop_sum};
    drop_next  = drop_total[8] ? 8'hFF : drop_total[7:0];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (push[i]) fifo_mem[i][wr_ptr[i]] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        rd_ptr[i]  <= '0;
        wr_ptr[i]  <= '0;
        count[i]   <= '0;
        arb_ptr[i] <= '0;
      end
      drop_count <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
        if (grant_vld[i])
          arb_ptr[i] <= (grant_idx[i] == LAST_PORT) ? '0 : grant_idx[i] + 1'b1;
      end
      drop_count <= drop_next;
    end
  end

  // Outputs are forced quiet for the whole time reset is held low
  assign in_full   = reset ? full_q     : '0;
  assign out_valid = reset ? grant_vld  : '0;
  assign out_data  = reset ? grant_data : '0;

endmodule

// File: tb/tb_xy_router_node.sv
// Bench for xy_router_node: directed sequences, a routing table and random
// traffic compared against a queue-based model of a 5-port node at (1,1).
module tb_xy_router_node;

  localparam int NP    = 5;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rst_next = 1'b0;

  logic [4:0]  in_valid, in_full, out_valid, out_full;
  logic [79:0] in_data, out_data;
  logic [7:0]  drop_count;

  logic [2:0]  in_valid3, in_full3, out_valid3, out_full3;
  logic [47:0] in_data3, out_data3;
  logic [7:0]  drop_count3;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [15:0] mq [NP][$];
  int          rr [NP];
  int          gnt[NP];

  typedef struct {
    int          src;
    logic [15:0] flit;
    int          exp_port;
    string       name;
  } vec_t;
  vec_t vecs[8];

  xy_router_node #(.NUM_PORTS(5), .DATA_WIDTH(16), .COORD_WIDTH(4),
                   .FIFO_DEPTH(4), .NODE_X(1), .NODE_Y(1)) dut5 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_full(in_full), .out_valid(out_valid), .out_data(out_data),
    .out_full(out_full), .drop_count(drop_count));

  xy_router_node #(.NUM_PORTS(3), .DATA_WIDTH(16), .COORD_WIDTH(4),
                   .FIFO_DEPTH(4), .NODE_X(1), .NODE_Y(1)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid3), .in_data(in_data3),
    .in_full(in_full3), .out_valid(out_valid3), .out_data(out_data3),
    .out_full(out_full3), .drop_count(drop_count3));

  always #5 clk = ~clk;

  function automatic int routeOf(logic [15:0] f);
    int dx, dy;
    dx = int'(f[15:12]);
    dy = int'(f[11:8]);
    if (dx > 1) return 1;
    if (dx < 1) return 2;
    if (dy > 1) return 3;
    if (dy < 1) return 4;
    return 0;
  endfunction

  function automatic logic [79:0] onePort(int p, logic [15:0] f);
    return 80'(f) << (p * 16);
  endfunction

  function automatic void computeGrants();
    int i;
    for (int o = 0; o < NP; o++) begin
      gnt[o] = -1;
      if (reset && !out_full[o]) begin
        for (int off = 0; off < NP; off++) begin
          i = (rr[o] + off) % NP;
          if (gnt[o] < 0 && mq[i].size() > 0 && routeOf(mq[i][0]) == o) gnt[o] = i;
        end
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model advances on the same edge the DUT does, using the inputs held that cycle
  always @(posedge clk) begin
    int pre[NP];
    if (!reset) begin
      for (int i = 0; i < NP; i++) begin
        mq[i].delete();
        rr[i] = 0;
      end
    end else begin
      for (int i = 0; i < NP; i++) pre[i] = mq[i].size();
      computeGrants();
      for (int o = 0; o < NP; o++) begin
        if (gnt[o] >= 0) begin
          void'(mq[gnt[o]].pop_front());
          rr[o] = (gnt[o] + 1) % NP;
        end
      end
      for (int i = 0; i < NP; i++)
        if (in_valid[i] && pre[i] < DEPTH) mq[i].push_back(in_data[i*16 +: 16]);
    end
  end

  task automatic modelCompare();
    logic [4:0]  ev, ef;
    logic [79:0] ed;
    computeGrants();
    ev = '0; ef = '0; ed = '0;
    for (int o = 0; o < NP; o++) begin
      if (gnt[o] >= 0) begin
        ev[o]        = 1'b1;
        ed[o*16 +: 16] = mq[gnt[o]][0];
      end
    end
    for (int i = 0; i < NP; i++)
      if (reset && mq[i].size() == DEPTH) ef[i] = 1'b1;
    checkOutput("model out_valid", 80'(out_valid), 80'(ev));
    checkOutput("model out_data", out_data, ed);
    checkOutput("model in_full", 80'(in_full), 80'(ef));
    checkOutput("model drop_count", 80'(drop_count), 80'(0));
  endtask

  task automatic applyStimulus(input logic [4:0] v, input logic [79:0] d, input logic [4:0] of);
    @(negedge clk);
    reset    = rst_next;
    in_valid = v;
    in_data  = d;
    out_full = of;
    #1;
    modelCompare();
  endtask

  task automatic applyStimulus3(input logic [2:0] v, input logic [47:0] d);
    @(negedge clk);
    in_valid3 = v;
    in_data3  = d;
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic       any_valid3;
    logic [4:0] rv, rf;
    logic [79:0] rd;

    in_valid = '0; in_data = '0; out_full = '0;
    in_valid3 = '0; in_data3 = '0; out_full3 = '0;

    vecs[0] = '{0, 16'h2155, 1, "east"};
    vecs[1] = '{0, 16'h0155, 2, "west"};
    vecs[2] = '{2, 16'h1255, 3, "north"};
    vecs[3] = '{1, 16'h1055, 4, "south"};
    vecs[4] = '{3, 16'h1100, 0, "local"};
    vecs[5] = '{1, 16'h2000, 1, "uturn east"};
    vecs[6] = '{4, 16'hF0FF, 1, "far east"};
    vecs[7] = '{4, 16'h10AA, 4, "uturn south"};

    // Reset held low with traffic offered, then released
    rst_next = 1'b0;
    for (int c = 0; c < 2; c++) begin
      applyStimulus(5'h1F, {$urandom, $urandom, 16'h2155}, 5'h00);
      checkOutput("reset out_valid", 80'(out_valid), 80'(0));
      checkOutput("reset in_full", 80'(in_full), 80'(0));
      checkOutput("reset drop_count", 80'(drop_count), 80'(0));
    end
    rst_next = 1'b1;
    applyStimulus(5'h00, 80'h0, 5'h00);
    checkOutput("post-reset out_valid", 80'(out_valid), 80'(0));
    checkOutput("post-reset in_full", 80'(in_full), 80'(0));
    checkOutput("post-reset drop_count", 80'(drop_count), 80'(0));

    for (int k = 0; k < 8; k++) begin
      applyStimulus(5'(1 << vecs[k].src), onePort(vecs[k].src, vecs[k].flit), 5'h00);
      applyStimulus(5'h00, 80'h0, 5'h00);
      checkOutput({vecs[k].name, " valid"}, 80'(out_valid), 80'(1 << vecs[k].exp_port));
      checkOutput({vecs[k].name, " data"}, 80'(out_data[vecs[k].exp_port*16 +: 16]), 80'(vecs[k].flit));
    end

    // Back-to-back injection from the local port to three different outputs
    applyStimulus(5'h01, onePort(0, 16'h2155), 5'h00);
    applyStimulus(5'h01, onePort(0, 16'h1055), 5'h00);
    checkOutput("seq east valid", 80'(out_valid), 80'(5'b00010));
    checkOutput("seq east data", 80'(out_data[31:16]), 80'(16'h2155));
    applyStimulus(5'h01, onePort(0, 16'h1100), 5'h00);
    checkOutput("seq south valid", 80'(out_valid), 80'(5'b10000));
    checkOutput("seq south data", 80'(out_data[79:64]), 80'(16'h1055));
    applyStimulus(5'h00, 80'h0, 5'h00);
    checkOutput("seq local valid", 80'(out_valid), 80'(5'b00001));
    checkOutput("seq local data", 80'(out_data[15:0]), 80'(16'h1100));

    // Three-way contention for the local output, then two continuous streams
    applyStimulus(5'b01110, onePort(1, 16'h11A1) | onePort(2, 16'h11A2) | onePort(3, 16'h11A3), 5'h00);
    for (int s = 1; s <= 3; s++) begin
      applyStimulus(5'h00, 80'h0, 5'h00);
      checkOutput("contend valid", 80'(out_valid), 80'(5'b00001));
      checkOutput("contend data", 80'(out_data[15:0]), 80'({12'h11A, 4'(s)}));
    end
    for (int j = 0; j < 10; j++) begin
      applyStimulus(5'b00110, onePort(1, {8'h11, 4'h1, 4'(j)}) | onePort(2, {8'h11, 4'h2, 4'(j)}), 5'h00);
      if (j >= 1) begin
        checkOutput("stream valid", 80'(out_valid[0]), 80'(1));
        checkOutput("stream source", 80'(out_data[7:4]), 80'((j % 2 == 1) ? 1 : 2));
      end
    end
    for (int c = 0; c < 12; c++) applyStimulus(5'h00, 80'h0, 5'h00);

    // Blocked east output fills FIFO 0; fifth flit is refused
    for (int n = 1; n <= 5; n++) begin
      applyStimulus(5'h01, onePort(0, 16'h2000 + 16'(n)), 5'b00010);
      checkOutput("blocked valid", 80'(out_valid[1]), 80'(0));
      checkOutput("blocked in_full", 80'(in_full[0]), 80'(n == 5));
    end
    applyStimulus(5'h00, 80'h0, 5'b00010);
    checkOutput("blocked hold full", 80'(in_full[0]), 80'(1));
    checkOutput("blocked hold valid", 80'(out_valid[1]), 80'(0));
    for (int n = 1; n <= 4; n++) begin
      applyStimulus(5'h00, 80'h0, 5'h00);
      checkOutput("unblock valid", 80'(out_valid[1]), 80'(1));
      checkOutput("unblock data", 80'(out_data[31:16]), 80'(16'h2000 + 16'(n)));
    end
    applyStimulus(5'h00, 80'h0, 5'h00);
    checkOutput("unblock drained", 80'(out_valid[1]), 80'(0));

    // Three-port node: a north-bound flit has nowhere to go
    applyStimulus3(3'b001, 48'(16'h1200));
    applyStimulus3(3'b001, 48'(16'h2100));
    checkOutput("drop head valid", 80'(out_valid3), 80'(0));
    checkOutput("drop head count", 80'(drop_count3), 80'(0));
    applyStimulus3(3'b000, 48'h0);
    checkOutput("after drop valid", 80'(out_valid3), 80'(3'b010));
    checkOutput("after drop data", 80'(out_data3[31:16]), 80'(16'h2100));
    checkOutput("after drop count", 80'(drop_count3), 80'(1));
    applyStimulus3(3'b000, 48'h0);
    checkOutput("drop idle valid", 80'(out_valid3), 80'(0));
    checkOutput("drop idle count", 80'(drop_count3), 80'(1));
    any_valid3 = 1'b0;
    for (int c = 0; c < 90; c++) begin
      applyStimulus3(3'b111, {3{16'h1200}});
      any_valid3 = any_valid3 | (|out_valid3);
    end
    for (int c = 0; c < 3; c++) applyStimulus3(3'b000, 48'h0);
    checkOutput("drop saturate", 80'(drop_count3), 80'(255));
    checkOutput("drop never sent", 80'(any_valid3), 80'(0));

    // Reset pulse discards buffered flits
    for (int n = 1; n <= 3; n++) applyStimulus(5'h01, onePort(0, 16'h2010 + 16'(n)), 5'b00010);
    applyStimulus(5'h00, 80'h0, 5'b00010);
    checkOutput("prepulse in_full", 80'(in_full[0]), 80'(0));
    rst_next = 1'b0;
    applyStimulus(5'h00, 80'h0, 5'b00010);
    checkOutput("pulse out_valid", 80'(out_valid), 80'(0));
    rst_next = 1'b1;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(5'h00, 80'h0, 5'h00);
      checkOutput("flushed out_valid", 80'(out_valid), 80'(0));
      checkOutput("flushed in_full", 80'(in_full), 80'(0));
      checkOutput("flushed drop_count", 80'(drop_count), 80'(0));
    end

    // Random traffic with random backpressure against the model
    for (int c = 0; c < 400; c++) begin
      rv = 5'($urandom);
      rf = 5'($urandom) & 5'($urandom);
      for (int p = 0; p < NP; p++)
        rd[p*16 +: 16] = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 2)), 8'($urandom)};
      applyStimulus(rv, rd, rf);
    end
    for (int c = 0; c < 20; c++) applyStimulus(5'h00, 80'h0, 5'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
